pipelined_adder: RTL and testbench

//   Parametrised, pipelined N-bit add/subtract unit with valid/ready handshakes on both sides.

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_stage.sv | 51 +++++
 rtl/pipelined_adder.sv | 103 ++++++++++
 tb/tb_pipelined_adder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared defaults and configuration check for the pipelined add/subtract unit.
package adder_pkg;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   function automatic bit adder_cfg_ok(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: registered CHUNK-bit add with carry, plus its valid bit and advance logic.
module adder_stage #(
   parameter int CHUNK = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_vld,
   input  logic             i_nxt_free,
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic             o_vld,
   output logic             o_ld,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_cmsb
);

   logic [CHUNK:0]   w_add;
   logic             r_vld;
   logic [CHUNK-1:0] r_sum;
   logic             r_cout;
   logic             r_cmsb;

   // Slot is free when empty or when its occupant moves on this edge.
   assign o_ld  = ~r_vld | i_nxt_free;
   assign w_add = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld  <= 1'b0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_cmsb <= 1'b0;
      end else if (o_ld) begin
         r_vld <= i_vld;
         if (i_vld) begin
            r_sum  <= w_add[CHUNK-1:0];
            r_cout <= w_add[CHUNK];
            // Carry into the top bit recovered from the sum bit and its operands.
            r_cmsb <= w_add[CHUNK-1] ^ i_a[CHUNK-1] ^ i_b[CHUNK-1];
         end
      end
   end

   assign o_vld  = r_vld;
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_cmsb = r_cmsb;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides; one CHUNK per stage,
// operand upper chunks and finished sum chunks skewed alongside each beat.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CARRY_IN,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] SUM,
   output logic             CARRY_OUT,
   output logic             OVERFLOW,
   output logic             ZERO
);

   localparam int CHUNK = WIDTH / ((STAGES > 0) ? STAGES : 1);

   if (!adder_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH=%0d must be >= 2 and a multiple of STAGES=%0d", WIDTH, STAGES);
   end

   logic [STAGES-1:0]            w_vin, w_cin, w_nxt_free, w_vld, w_ld, w_cout, w_cmsb;
   logic [STAGES-1:0][CHUNK-1:0] w_sum;
   logic [STAGES-1:0][WIDTH-1:0] w_a_src, w_b_src, w_s_src;
   logic [STAGES-1:0][WIDTH-1:0] w_a_q, w_b_q, w_s_q;
   logic                         w_unused;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] r_a, r_b, r_s;

      if (k == 0) begin : g_head
         assign w_vin[k]   = IN_VALID;
         assign w_cin[k]   = SUB ^ CARRY_IN;
         assign w_a_src[k] = A;
         assign w_b_src[k] = SUB ? ~B : B;
         assign w_s_src[k] = '0;
      end else begin : g_body
         assign w_vin[k]   = w_vld[k-1];
         assign w_cin[k]   = w_cout[k-1];
         assign w_a_src[k] = w_a_q[k-1];
         assign w_b_src[k] = w_b_q[k-1];
         assign w_s_src[k] = w_s_q[k-1] | (WIDTH'(w_sum[k-1]) << ((k-1) * CHUNK));
      end

      if (k == STAGES-1) begin : g_tail
         assign w_nxt_free[k] = OUT_READY;
      end else begin : g_link
         assign w_nxt_free[k] = w_ld[k+1];
      end

      always_ff @(posedge CLK) begin
         if (w_ld[k] && w_vin[k]) begin
            r_a <= w_a_src[k];
            r_b <= w_b_src[k];
         end
      end

      // Lower sum chunks reach SUM at the last stage, so they carry a reset.
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N)                 r_s <= '0;
         else if (w_ld[k] && w_vin[k]) r_s <= w_s_src[k];
      end

      assign w_a_q[k] = r_a;
      assign w_b_q[k] = r_b;
      assign w_s_q[k] = r_s;

      adder_stage #(.CHUNK(CHUNK)) u_stage (
         .i_clk      (CLK),
         .i_rst_n    (RESET_N),
         .i_vld      (w_vin[k]),
         .i_nxt_free (w_nxt_free[k]),
         .i_a        (w_a_src[k][k*CHUNK +: CHUNK]),
         .i_b        (w_b_src[k][k*CHUNK +: CHUNK]),
         .i_cin      (w_cin[k]),
         .o_vld      (w_vld[k]),
         .o_ld       (w_ld[k]),
         .o_sum      (w_sum[k]),
         .o_cout     (w_cout[k]),
         .o_cmsb     (w_cmsb[k])
      );
   end

   assign IN_READY  = w_ld[0];
   assign OUT_VALID = w_vld[STAGES-1];
   assign SUM       = w_s_q[STAGES-1] | (WIDTH'(w_sum[STAGES-1]) << ((STAGES-1) * CHUNK));
   assign CARRY_OUT = w_cout[STAGES-1];
   assign OVERFLOW  = w_cout[STAGES-1] ^ w_cmsb[STAGES-1];
   assign ZERO      = OUT_VALID & (SUM == '0);

   // Last-stage operand copies and inner MSB carries have no consumer.
   assign w_unused = ^{w_a_q[STAGES-1], w_b_q[STAGES-1], w_cmsb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised bench for pipelined_adder in three shapes (32/4, 8/1, 64/8) against an arithmetic model.
module tb_pipelined_adder;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Returns {overflow, zero, carry_out, sum zero-extended to 64}.
   function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic sub, input logic cin);
      logic [63:0] m, am, be, s;
      logic [64:0] t;
      logic        co, ov;
      m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      am = a & m;
      be = (sub ? ~b : b) & m;
      t  = {1'b0, am} + {1'b0, be} + 65'(sub ^ cin);
      s  = t[63:0] & m;
      co = t[w];
      ov = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
      return {ov, (s == 64'd0), co, s};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int W = (g == 0) ? 32 : (g == 1) ? 8 : 64;
      localparam int S = (g == 0) ? 4  : (g == 1) ? 1 : 8;

      logic         RESET_N, IN_VALID, IN_READY, CARRY_IN, SUB;
      logic         OUT_VALID, OUT_READY, CARRY_OUT, OVERFLOW, ZERO;
      logic [W-1:0] A, B, SUM;

      logic [67:0] exp_q[$];
      int          acc_q[$];
      int          ncyc = 0, n_out = 0, mark = -1, first_out = 0, last_out = 0, last_stall = -1;
      logic [67:0] last_res = '0, prev = '0;
      logic        pv = 1'b0, pr = 1'b0;
      bit          stop = 1'b0, fin = 1'b0;

      pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
         .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
         .A(A), .B(B), .CARRY_IN(CARRY_IN), .SUB(SUB),
         .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM),
         .CARRY_OUT(CARRY_OUT), .OVERFLOW(OVERFLOW), .ZERO(ZERO)
      );

      // Monitor: handshakes seen at the falling edge complete on the next rising edge.
      initial forever begin
         @(negedge CLK);
         ncyc++;
         if (RESET_N !== 1'b1) begin
            exp_q.delete();
            acc_q.delete();
            pv = 1'b0;
         end else begin
            if (pv && !pr)
               chk($sformatf("c%0d hold", g), {OUT_VALID, OVERFLOW, ZERO, CARRY_OUT, 64'(SUM)}, prev);
            if (OUT_VALID && exp_q.size() == 0)
               chk($sformatf("c%0d spurious_out", g), 68'(OUT_VALID), 68'd0);
            else if (OUT_VALID && OUT_READY) begin
               int ta;
               ta = acc_q.pop_front();
               last_res = {OVERFLOW, ZERO, CARRY_OUT, 64'(SUM)};
               chk($sformatf("c%0d result", g), last_res, exp_q.pop_front());
               if (ta > last_stall)
                  chk($sformatf("c%0d latency", g), 68'(ncyc - ta), 68'(S));
               if (n_out == mark) first_out = ncyc;
               n_out++;
               last_out = ncyc;
            end
            if (OUT_VALID && !OUT_READY) last_stall = ncyc;
            if (IN_VALID && IN_READY) begin
               exp_q.push_back(model(W, 64'(A), 64'(B), SUB, CARRY_IN));
               acc_q.push_back(ncyc);
            end
            pv   = OUT_VALID;
            pr   = OUT_READY;
            prev = {OUT_VALID, OVERFLOW, ZERO, CARRY_OUT, 64'(SUM)};
         end
      end

      task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic c);
         int  tmo;
         logic acc;
         A = a; B = b; SUB = s; CARRY_IN = c; IN_VALID = 1'b1;
         tmo = 0;
         do begin
            @(negedge CLK);
            acc = IN_READY;
            tmo++;
         end while (!acc && tmo < 200);
         @(posedge CLK);
         #1;
         chk($sformatf("c%0d accept", g), 68'(acc), 68'd1);
      endtask

      task automatic send_rand();
         send(W'({$urandom(), $urandom()}), W'({$urandom(), $urandom()}),
              1'($urandom()), 1'($urandom()));
      endtask

      task automatic drain();
         IN_VALID = 1'b0;
         for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
         #1;
         chk($sformatf("c%0d drain", g), 68'(exp_q.size()), 68'd0);
      endtask

      initial begin
         logic [W-1:0] v;
         int           nacc;
         logic         acc;
         RESET_N = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
         A = '0; B = '0; SUB = 1'b0; CARRY_IN = 1'b0;
         #12;
         chk($sformatf("c%0d rst_outs", g), {OUT_VALID, OVERFLOW, ZERO, CARRY_OUT, 64'(SUM)}, 68'd0);
         @(posedge CLK);
         #1 RESET_N = 1'b1;
         #1 chk($sformatf("c%0d rst_ready", g), 68'(IN_READY), 68'd1);

         // All-ones plus one wraps to zero with carry.
         send('1, W'(1), 1'b0, 1'b0);
         drain();
         chk($sformatf("c%0d wrap", g), last_res, {1'b0, 1'b1, 1'b1, 64'd0});

         // 5 - 7 borrows.
         send(W'(5), W'(7), 1'b1, 1'b0);
         drain();
         v = '1;
         v = v - W'(1);
         chk($sformatf("c%0d sub_neg", g), last_res, {1'b0, 1'b0, 1'b0, 64'(v)});

         // Max positive plus one overflows into the sign bit.
         v = '1;
         v[W-1] = 1'b0;
         send(v, W'(1), 1'b0, 1'b0);
         drain();
         v = '0;
         v[W-1] = 1'b1;
         chk($sformatf("c%0d ovf", g), last_res, {1'b1, 1'b0, 1'b0, 64'(v)});

         // Back-to-back stream must emerge one per cycle.
         mark = n_out;
         repeat (100) send_rand();
         drain();
         chk($sformatf("c%0d b2b_count", g), 68'(n_out - mark), 68'd100);
         chk($sformatf("c%0d b2b_span", g), 68'(last_out - first_out), 68'd99);

         // Back-pressure for six cycles while the source keeps offering beats.
         OUT_READY = 1'b0;
         A = W'({$urandom(), $urandom()}); B = W'({$urandom(), $urandom()});
         SUB = 1'($urandom()); CARRY_IN = 1'($urandom()); IN_VALID = 1'b1;
         nacc = 0;
         repeat (6) begin
            @(negedge CLK);
            acc = IN_READY;
            @(posedge CLK);
            #1;
            if (acc) begin
               nacc++;
               A = W'({$urandom(), $urandom()}); B = W'({$urandom(), $urandom()});
               SUB = 1'($urandom()); CARRY_IN = 1'($urandom());
            end
         end
         chk($sformatf("c%0d stall_accepts", g), 68'(nacc), 68'((S < 6) ? S : 6));
         chk($sformatf("c%0d stall_ready", g), 68'(IN_READY), 68'(S > 6));
         IN_VALID = 1'b0;
         OUT_READY = 1'b1;
         drain();

         // Random gaps on the input with random back-pressure on the output.
         stop = 1'b0;
         fork
            begin
               for (int i = 0; i < 60; i++) begin
                  if ($urandom_range(2) == 0) begin
                     IN_VALID = 1'b0;
                     @(posedge CLK);
                     #1;
                  end
                  send_rand();
               end
               IN_VALID = 1'b0;
               stop = 1'b1;
            end
            while (!stop) begin
               @(posedge CLK);
               #1 OUT_READY = ($urandom_range(3) != 0);
            end
         join
         OUT_READY = 1'b1;
         drain();

         // Reset while beats are in flight: nothing may come out afterwards.
         repeat (3) send_rand();
         @(posedge CLK);
         #3 RESET_N = 1'b0;
         #1 chk($sformatf("c%0d midrst_outs", g), {OUT_VALID, OVERFLOW, ZERO, CARRY_OUT, 64'(SUM)}, 68'd0);
         IN_VALID = 1'b0;
         @(posedge CLK);
         #1 RESET_N = 1'b1;
         #1 chk($sformatf("c%0d midrst_ready", g), 68'(IN_READY), 68'd1);
         repeat (2 * S + 4) @(posedge CLK);
         #1 chk($sformatf("c%0d midrst_idle", g), 68'(OUT_VALID), 68'd0);
         fin = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 60000 && !(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin); i++)
         @(posedge CLK);
      chk("all_done", 68'({g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin}), 68'd7);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
